// File: rtl/gcd_multi_ci_if.sv
// gcd_multi_ci_if: custom-instruction bus (clk_en/start/n/dataa/datab in, done/result out) for gcd_multi_ci
interface gcd_multi_ci_if #(parameter int WIDTH = 32);
  logic             clk_en;
  logic             start;
  logic [1:0]       n;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             done;
  logic [WIDTH-1:0] result;
  modport master (output clk_en, start, n, dataa, datab, input done, result);
  modport slave (input clk_en, start, n, dataa, datab, output done, result);
endinterface

// File: rtl/gcd_multi_ci.sv
// gcd_multi_ci: multicycle binary-GCD custom instruction; clk, reset (async high), bus = gcd_multi_ci_if slave; n selects GCD / step count / coprime flag
module gcd_multi_ci #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  gcd_multi_ci_if.slave bus
);
  localparam int KW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a, b, a_nx, b_nx, g, result, result_nx;
  logic [KW-1:0]    k, k_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       mode, mode_nx;
  logic             done, done_nx;
  assign bus.done   = done;
  assign bus.result = result;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      cnt    <= '0;
      mode   <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (bus.clk_en) begin
      state  <= state_nx;
      a      <= a_nx;
      b      <= b_nx;
      k      <= k_nx;
      cnt    <= cnt_nx;
      mode   <= mode_nx;
      done   <= done_nx;
      result <= result_nx;
    end
  always_comb begin
    state_nx  = state;
    a_nx      = a;
    b_nx      = b;
    k_nx      = k;
    cnt_nx    = cnt;
    mode_nx   = mode;
    done_nx   = done;
    result_nx = result;
    g         = (a == '0) ? b : a << k;
    if (state == IDLE) begin
      done_nx = 1'b0;
      if (bus.start) begin
        a_nx     = bus.dataa;
        b_nx     = bus.datab;
        mode_nx  = bus.n;
        k_nx     = '0;
        cnt_nx   = '0;
        state_nx = RUN;
      end
    end else begin
      cnt_nx = (&cnt) ? cnt : cnt + 1'b1;
      if (a == '0 || b == '0) begin
        state_nx  = IDLE;
        done_nx   = 1'b1;
        result_nx = (mode == 2'd1) ? WIDTH'(cnt_nx) : (mode == 2'd2) ? WIDTH'(g == WIDTH'(1)) : g;
      end else if (!a[0] && !b[0]) begin
        a_nx = a >> 1;
        b_nx = b >> 1;
        k_nx = k + 1'b1;
      end else if (!a[0]) a_nx = a >> 1;
      else if (!b[0]) b_nx = b >> 1;
      else if (a > b) begin
        a_nx = b;
        b_nx = a - b;
      end else b_nx = b - a;
    end
  end
endmodule

// File: tb/tb_gcd_multi_ci.sv
// tb_gcd_multi_ci: randomized scoreboard bench for gcd_multi_ci at WIDTH=32 and WIDTH=16
module tb_gcd_multi_ci;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  always #5 clk = ~clk;
  gcd_multi_ci_if #(.WIDTH(32)) i32 ();
  gcd_multi_ci_if #(.WIDTH(16)) i16 ();
  assign i32.clk_en = ce;
  assign i16.clk_en = ce;
  gcd_multi_ci #(.WIDTH(32), .CNT_W(16)) dut32 (.clk(clk), .reset(reset), .bus(i32.slave));
  gcd_multi_ci #(.WIDTH(16), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(i16.slave));
  typedef struct {logic [31:0] res; int due;} exp_t;
  exp_t q32[$];
  exp_t q16[$];
  int checks = 0;
  int passed = 0;
  int qcnt = 0;
  bit just_q = 1'b0;
  always @(posedge clk) begin
    just_q <= ce;
    if (ce) qcnt <= qcnt + 1;
  end
  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask
  function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  function automatic int stein_steps(input longint unsigned x, input longint unsigned y);
    int s = 0;
    longint unsigned t;
    forever begin
      s++;
      if (x == 0 || y == 0) return s;
      if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) begin t = x - y; x = y; y = t; end
      else y = y - x;
    end
  endfunction
  function automatic logic [31:0] ref_result(input longint unsigned x, input longint unsigned y, input logic [1:0] m);
    longint unsigned g = ref_gcd(x, y);
    int s = stein_steps(x, y);
    if (m == 2'd1) return (s > 65535) ? 32'd65535 : 32'(s);
    if (m == 2'd2) return {31'd0, g == 1};
    return 32'(g);
  endfunction
  exp_t m32, m16;
  bit pd32 = 1'b0;
  bit pd16 = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (just_q && i32.done) begin
        if (q32.size() == 0) chk("spurious_done32", 1, 0);
        else begin
          m32 = q32.pop_front();
          chk("result32", i32.result, m32.res);
          chk("latency32", qcnt, m32.due);
        end
      end
      if (just_q && i16.done) begin
        if (q16.size() == 0) chk("spurious_done16", 1, 0);
        else begin
          m16 = q16.pop_front();
          chk("result16", i16.result, m16.res);
          chk("latency16", qcnt, m16.due);
        end
      end
      if (!just_q) begin
        chk("done_hold32", i32.done, pd32);
        chk("done_hold16", i16.done, pd16);
      end
    end
    pd32 = i32.done;
    pd16 = i16.done;
  end
  task automatic issue(input bit w16, input logic [31:0] x, input logic [31:0] y, input logic [1:0] m, input bit push);
    exp_t e;
    logic [31:0] xa, ya;
    xa = w16 ? {16'd0, x[15:0]} : x;
    ya = w16 ? {16'd0, y[15:0]} : y;
    ce = 1'b1;
    if (w16) begin
      i16.start = 1'b1; i16.dataa = xa[15:0]; i16.datab = ya[15:0]; i16.n = m;
    end else begin
      i32.start = 1'b1; i32.dataa = xa; i32.datab = ya; i32.n = m;
    end
    @(posedge clk);
    #1;
    i32.start = 1'b0;
    i16.start = 1'b0;
    if (push) begin
      e.res = ref_result(xa, ya, m);
      e.due = qcnt + stein_steps(xa, ya);
      if (w16) q16.push_back(e);
      else q32.push_back(e);
    end
  endtask
  task automatic drain(input bit toggle);
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 3000) begin
      @(negedge clk);
      ce = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (q32.size() != 0 || q16.size() != 0) begin
      chk("drain_timeout", q32.size() + q16.size(), 0);
      q32.delete();
      q16.delete();
    end
    @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    int n;
    logic [31:0] x, y;
    i32.start = 1'b0; i32.n = 2'd0; i32.dataa = '0; i32.datab = '0;
    i16.start = 1'b0; i16.n = 2'd0; i16.dataa = '0; i16.datab = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_done32", i32.done, 0);
    chk("reset_result32", i32.result, 0);
    chk("reset_done16", i16.done, 0);
    chk("reset_result16", i16.result, 0);
    issue(0, 48, 18, 0, 1); drain(0);
    issue(0, 48, 18, 1, 1); drain(0);
    issue(0, 48, 18, 2, 1); drain(0);
    issue(0, 48, 18, 3, 1); drain(0);
    issue(0, 0, 5, 0, 1); drain(0);
    issue(0, 7, 0, 0, 1); drain(0);
    issue(0, 0, 0, 0, 1); drain(0);
    issue(0, 0, 5, 2, 1); drain(0);
    issue(0, 0, 0, 2, 1); drain(0);
    issue(0, 0, 0, 1, 1); drain(0);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1); drain(0);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1); drain(0);
    issue(1, 32'h8000, 32'h4000, 0, 1); drain(0);
    issue(1, 32'h8000, 32'h4000, 1, 1); drain(0);
    issue(1, 32'hFFFF, 32'hFFFF, 0, 1); drain(0);
    issue(0, 48, 18, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_done", i32.done, 0);
    chk("midrun_reset_result", i32.result, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(0, 48, 18, 0, 1); drain(0);
    issue(0, 48, 18, 0, 1); drain(1);
    issue(0, 48, 18, 1, 1); drain(1);
    issue(0, 48, 18, 0, 1);
    repeat (3) @(negedge clk);
    i32.start = 1'b1; i32.dataa = 9; i32.datab = 6; i32.n = 2'd1;
    @(negedge clk);
    i32.start = 1'b0;
    drain(0);
    issue(0, 48, 18, 0, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(just_q && i32.done) && n < 100);
    if (n >= 100) chk("b2b_timeout", n, 0);
    issue(0, 9, 6, 0, 1);
    drain(0);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = $urandom_range(0, 20); y = $urandom_range(0, 20); end
        2: begin x = $urandom_range(1, 999) << $urandom_range(0, 12); y = $urandom_range(1, 999) << $urandom_range(0, 12); end
        default: begin x = $urandom; y = x * $urandom_range(1, 3); end
      endcase
      issue(1'(i % 2), x, y, 2'($urandom_range(0, 3)), 1);
      drain(1'(i % 3 == 0));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gcd_multi_ci.md
Name: gcd_multi_ci

Overview:
Parametrised multicycle Nios II custom-instruction GCD engine, the successor to the single-mode 32-bit GCD instruction.
- Uses the binary (Stein) algorithm: shift and subtract only, no divider.
- Runtime mode selected per instruction through the custom-instruction n field.
- Sits on the CPU custom-instruction port alongside the other *_ci blocks.

Parameters:
WIDTH, 32, operand and result width in bits (>= 8)
CNT_W, 16, step-counter width; must be <= WIDTH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  CPU clock enable; all state advances only when high
start  in  1  one-cycle instruction start, qualified by clk_en
n  in  2  mode: 0=GCD, 1=step count, 2=coprime flag, 3=GCD
dataa  in  WIDTH  operand A
datab  in  WIDTH  operand B
done  out  1  registered; high for exactly one clk_en-qualified cycle per operation
result  out  WIDTH  registered; holds the last result until the next done

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; done=0; result=0; internal a, b, k, cnt, mode cleared.
- clk_en low: every register holds, including done. done therefore stays high until the next clk_en edge.
- IDLE:
  - On a clk_en edge with start=1: a<=dataa, b<=datab, mode<=n, k<=0, cnt<=0, done<=0; go to RUN.
  - start=0: done<=0.
- start while in RUN is ignored; the operation in flight continues.
- RUN, one step per clk_en edge:
  - cnt<=cnt+1, saturating at 2^CNT_W-1.
  - The count includes the terminating step.
  - Rules are evaluated in priority order; the first match applies.
  1. a==0: finish with g=b.
  2. b==0: finish with g=a<<k.
  3. a,b both even: a<=a>>1, b<=b>>1, k<=k+1.
  4. a even: a<=a>>1.
  5. b even: b<=b>>1.
  6. a>b: a<=b, b<=a-b (unsigned, WIDTH bits).
  7. otherwise: b<=b-a.
- Invariants:
  - Once a is odd it stays odd, so rule 1 can fire only on the first step.
  - k <= WIDTH-1; the final shift never overflows because g <= max(dataa, datab).
- Finish, in the same edge as the terminating step:
  - done<=1; go to IDLE.
  - result depends on the latched mode:
    - mode 0/3: g.
    - mode 1: cnt+1, zero-extended to WIDTH.
    - mode 2: 1 if g==1, else 0.
- Latency:
  - start accepted at edge E; done is visible after edge E+S, where S = number of RUN steps (>=1).
  - Zero-operand cases give S=1.
- Back-to-back: start may be asserted on the cycle done is high. It is accepted (state is IDLE) and done drops on that edge.
- Boundary values:
  - gcd(0,0)=0; gcd(x,0)=x; gcd(0,x)=x.
  - Coprime flag for gcd(0,0) and gcd(0,x) (x != 1) is 0.
  - Full-scale operands are unsigned.

Test Plan:
- Reset then idle: done=0, result=0.
- Assert reset during RUN of gcd(48,18): done=0, result=0, IDLE. A fresh start afterwards works normally.
- WIDTH=32, n=0, A=48, B=18: done after edge E+8, result=6.
  - Repeat with n=1: result=8.
  - Repeat with n=2: result=0.
- n=0 zero operands:
  - (0,5) -> 5 after 1 step.
  - (7,0) -> 7 after 1 step.
  - (0,0) -> 0 after 1 step.
  - n=2 on (0,5) -> 0.
- n=2, A=0xFFFFFFFF, B=0xFFFFFFFE: result=1. Check the n=0 result is also 1.
- WIDTH=16, A=0x8000, B=0x4000:
  - n=0 -> 0x4000 after 17 steps.
  - n=1 -> 17.
- clk_en toggled low for random cycles during gcd(48,18): same result and step count; done held through clk_en-low cycles.
- Start pulsed mid-RUN: ignored, original result delivered.
- Back-to-back start on the done cycle: second op (9,6) -> 3.
